fadd_arbiter: RTL

- Shares one pipelined fadd unit (fixed latency NSTAGE) among NREQ requesters.
- Round-robin arbitration grants at most one operand pair per cycle.
- Operands are registered onto the fadd inputs; a tag/valid shift pipeline routes each fadd result and overflow flag back to the requester that issued it.
- Sits between the FPU dispatch logic and the shared fadd instance.

---
 rtl/fadd_arbiter_if.sv | 27 ++
 rtl/fadd_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/fadd_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the shared fadd unit.
// slave is the arbiter's view; master is the requester/fadd side.
interface fadd_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_x1;
    logic [32*NREQ-1:0]   req_x2;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          fadd_x1;
    logic [31:0]          fadd_x2;
    logic [31:0]          fadd_y;
    logic                 fadd_ovf;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_y;
    logic                 resp_ovf;

    modport slave (
        input  req_valid, req_x1, req_x2, fadd_y, fadd_ovf,
        output req_ready, fadd_x1, fadd_x2, resp_valid, resp_y, resp_ovf
    );

    modport master (
        output req_valid, req_x1, req_x2, fadd_y, fadd_ovf,
        input  req_ready, fadd_x1, fadd_x2, resp_valid, resp_y, resp_ovf
    );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined fadd among NREQ requesters;
// a tag/valid shift pipeline steers each result back to the requester that issued it.
module fadd_arbiter #(
    parameter int NSTAGE = 2,
    parameter int NREQ   = 4,
    parameter int TW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    fadd_arbiter_if.slave bus,
    output logic          busy,
    output logic [31:0]   issue_cnt
);
    logic [TW-1:0]           ptr;
    logic [TW-1:0]           ptr_next;
    logic [TW-1:0]           idx;
    logic [TW-1:0]           grant_idx;
    logic                    grant;
    logic [31:0]             sel_x1;
    logic [31:0]             sel_x2;
    logic [31:0]             x1_q;
    logic [31:0]             x2_q;
    logic [NSTAGE:0]         val;
    logic [NSTAGE:0][TW-1:0] tag;

    // Search starts at ptr and wraps; the first active requester wins.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = TW'((int'(ptr) + i) % NREQ);
            if (!grant && bus.req_valid[idx]) begin
                grant     = 1'b1;
                grant_idx = idx;
            end
        end
        if (!rstn) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == TW'(i)) begin
                sel_x1 = bus.req_x1[32*i +: 32];
                sel_x2 = bus.req_x2[32*i +: 32];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);

    // Operands hold their last value when idle; the fadd output is ignored then anyway.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            issue_cnt <= '0;
        end else if (grant) begin
            ptr       <= ptr_next;
            x1_q      <= sel_x1;
            x2_q      <= sel_x2;
            issue_cnt <= issue_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            val <= '0;
            tag <= '0;
        end else begin
            val <= {val[NSTAGE-1:0], grant};
            tag <= {tag[NSTAGE-1:0], grant_idx};
        end
    end

    assign bus.fadd_x1 = x1_q;
    assign bus.fadd_x2 = x2_q;

    always_comb begin
        bus.resp_valid = '0;
        if (val[NSTAGE]) begin
            bus.resp_valid[tag[NSTAGE]] = 1'b1;
        end
    end

    assign bus.resp_y   = bus.fadd_y;
    assign bus.resp_ovf = bus.fadd_ovf;
    assign busy         = |val;
endmodule
